video_hist_bank: RTL and testbench

Parametrised frame histogram unit on the pixel clock, placed between hdmi_rx and the CPU-facing register logic. It supersedes the single-channel hist_bin_* path: per-channel or luma histograms, configurable bin count, double-banked counters and a streamed readout with valid/ready handshake. While one frame accumulates, the previous frame's histogram is read out.

---
 rtl/video_hist_pkg.sv | 28 ++
 rtl/hist_readout_fsm.sv | 99 +++++++++
 rtl/video_hist_bank.sv | 160 ++++++++++++++++
 tb/tb_video_hist_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_hist_pkg.sv
// Shared types and helpers for the frame histogram unit.
package video_hist_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_t;

   localparam logic MODE_CHAN = 1'b0;
   localparam logic MODE_LUMA = 1'b1;

   // Y = (R + 2G + B) >> 2, computed two bits wider than a component so the sum never overflows.
   function automatic logic [17:0] luma_sum(input logic [15:0] r,
                                            input logic [15:0] g,
                                            input logic [15:0] b);
      logic [17:0] s;
      s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
      return s >> 2;
   endfunction

   // Top bin_w bits of a data_w-bit component value.
   function automatic logic [15:0] bin_index(input logic [15:0] v,
                                             input int data_w,
                                             input int bin_w);
      return 16'(v >> (data_w - bin_w));
   endfunction

endpackage

// File: rtl/hist_readout_fsm.sv
// Streams the idle bank word by word: ch-major, bins ascending, valid/ready handshake.
module hist_readout_fsm
   import video_hist_pkg::*;
#(
   parameter int BIN_W    = 4,
   parameter int CHANNELS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             swap_i,
   input  logic             luma_i,
   input  logic             rd_ready_i,
   output logic             rd_valid_o,
   output logic [1:0]       rd_ch_o,
   output logic [BIN_W-1:0] rd_bin_o,
   output logic             rd_last_o,
   output logic             overrun_o
);

   localparam int BINS = 2**BIN_W;

   rd_state_t        state_q;
   logic             valid_q;
   logic [1:0]       ch_q;
   logic [BIN_W-1:0] bin_q;
   logic             last_q;
   logic             overrun_q;

   logic [1:0]       ch_d;
   logic [BIN_W-1:0] bin_d;
   logic             last_d;

   // Address of the word following the current one, and whether it is the final word.
   always_comb begin
      ch_d  = ch_q;
      bin_d = bin_q + 1'b1;
      if (bin_q == BIN_W'(BINS - 1)) begin
         ch_d  = ch_q + 2'd1;
         bin_d = '0;
      end
      last_d = (bin_d == BIN_W'(BINS - 1)) &&
               (luma_i ? (ch_d == 2'd0) : (ch_d == 2'(CHANNELS - 1)));
   end

   // Readout state, index and handshake; a swap always restarts from word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         ch_q      <= '0;
         bin_q     <= '0;
         last_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (swap_i) begin
                  state_q <= STREAM;
                  valid_q <= 1'b1;
                  ch_q    <= '0;
                  bin_q   <= '0;
                  last_q  <= 1'b0;
               end
            end
            STREAM: begin
               if (swap_i) begin
                  overrun_q <= 1'b1;
                  ch_q      <= '0;
                  bin_q     <= '0;
                  last_q    <= 1'b0;
               end else if (rd_ready_i) begin
                  if (last_q) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     ch_q    <= '0;
                     bin_q   <= '0;
                     last_q  <= 1'b0;
                  end else begin
                     ch_q   <= ch_d;
                     bin_q  <= bin_d;
                     last_q <= last_d;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign rd_valid_o = valid_q;
   assign rd_ch_o    = ch_q;
   assign rd_bin_o   = bin_q;
   assign rd_last_o  = last_q;
   assign overrun_o  = overrun_q;

endmodule

// File: rtl/video_hist_bank.sv
// Double-banked frame histogram: one bank accumulates while the other is streamed out.
module video_hist_bank
   import video_hist_pkg::*;
#(
   parameter int   DATA_W   = 8,
   parameter int   BIN_W    = 4,
   parameter int   CHANNELS = 3,
   parameter int   CNT_W    = 22,
   parameter logic VS_POL   = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   input  logic                dv_i,
   input  logic                vs_i,
   input  logic [3*DATA_W-1:0] pix_i,
   output logic                rd_valid,
   output logic [CNT_W-1:0]    rd_data,
   output logic [1:0]          rd_ch,
   output logic [BIN_W-1:0]    rd_bin,
   output logic                rd_last,
   input  logic                rd_ready,
   output logic                frame_done,
   output logic                overrun
);

   localparam int               BINS    = 2**BIN_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   logic                act_q, en_q, mode_q, rd_mode_q;
   logic                vs_q, edge_d1_q, edge_d2_q, frame_done_q;
   logic [CHANNELS-1:0] inc_s1_q;
   logic [BIN_W-1:0]    bin_s1_q [CHANNELS];
   logic [CNT_W-1:0]    bank_q   [2][CHANNELS][BINS];
   logic [CNT_W-1:0]    bank_d   [2][CHANNELS][BINS];

   logic [CHANNELS-1:0] inc_d;
   logic [BIN_W-1:0]    bin_d [CHANNELS];
   logic [DATA_W-1:0]   luma;
   logic                vs_edge, swap, tgt;

   assign vs_edge = (vs_i == VS_POL) && (vs_q != VS_POL);
   assign swap    = edge_d2_q;
   // The increment that lands on the swap edge belongs to the new frame.
   assign tgt     = swap ? ~act_q : act_q;

   // Stage 1 inputs: bin index per channel and which channel lanes carry a pixel.
   always_comb begin
      luma = DATA_W'(luma_sum(16'(pix_i[3*DATA_W-1 -: DATA_W]),
                              16'(pix_i[2*DATA_W-1 -: DATA_W]),
                              16'(pix_i[DATA_W-1:0])));
      for (int c = 0; c < CHANNELS; c++) begin
         bin_d[c] = BIN_W'(bin_index(16'(pix_i[(3-c)*DATA_W-1 -: DATA_W]), DATA_W, BIN_W));
         inc_d[c] = dv_i && ((mode_q == MODE_CHAN) || (c == 0));
      end
      if (mode_q == MODE_LUMA) begin
         bin_d[0] = BIN_W'(bin_index(16'(luma), DATA_W, BIN_W));
      end
   end

   // ---- stage 1 -> stage 2 boundary ----
   // Bin indices are pure data; only the lane-valid bits need a reset.
   always_ff @(posedge clk) begin
      bin_s1_q <= bin_d;
   end

   // Frame control: sync edge delay, bank select and per-frame settings.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q         <= VS_POL;
         edge_d1_q    <= 1'b0;
         edge_d2_q    <= 1'b0;
         act_q        <= 1'b0;
         en_q         <= 1'b0;
         mode_q       <= MODE_CHAN;
         rd_mode_q    <= MODE_CHAN;
         frame_done_q <= 1'b0;
         inc_s1_q     <= '0;
      end else begin
         vs_q         <= vs_i;
         edge_d1_q    <= vs_edge;
         edge_d2_q    <= edge_d1_q;
         frame_done_q <= swap;
         inc_s1_q     <= inc_d;
         if (swap) begin
            act_q     <= ~act_q;
            en_q      <= en;
            mode_q    <= mode;
            rd_mode_q <= mode_q;
         end
      end
   end

   // Stage 2 counter update: clear of the new bank first, then the saturating increment.
   always_comb begin
      bank_d = bank_q;
      for (int b = 0; b < 2; b++) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < BINS; k++) begin
               if (swap && (1'(b) != act_q)) begin
                  bank_d[b][c][k] = '0;
               end
               if (en_q && inc_s1_q[c] && (bin_s1_q[c] == BIN_W'(k)) && (1'(b) == tgt)) begin
                  bank_d[b][c][k] = sat_inc(bank_d[b][c][k]);
               end
            end
         end
      end
   end

   // ---- stage 2 -> counter bank boundary ----
   // Counter storage; both banks start cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < CHANNELS; c++) begin
               for (int k = 0; k < BINS; k++) begin
                  bank_q[b][c][k] <= '0;
               end
            end
         end
      end else begin
         bank_q <= bank_d;
      end
   end

   hist_readout_fsm #(
      .BIN_W    (BIN_W),
      .CHANNELS (CHANNELS)
   ) u_readout (
      .clk        (clk),
      .rst_n      (rst_n),
      .swap_i     (swap),
      .luma_i     (rd_mode_q == MODE_LUMA),
      .rd_ready_i (rd_ready),
      .rd_valid_o (rd_valid),
      .rd_ch_o    (rd_ch),
      .rd_bin_o   (rd_bin),
      .rd_last_o  (rd_last),
      .overrun_o  (overrun)
   );

   // Readout mux over the idle bank, addressed by the registered readout index.
   always_comb begin
      rd_data = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rd_ch == 2'(c)) begin
            rd_data = bank_q[~act_q][c][rd_bin];
         end
      end
   end

   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_video_hist_bank.sv
// Directed bench for video_hist_bank: a default instance plus a CNT_W=4 copy for saturation.
module tb_video_hist_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        mode = 1'b0;
   logic        dv_i = 1'b0;
   logic        vs_i = 1'b0;
   logic [23:0] pix_i = '0;
   logic        rd_ready = 1'b0;

   logic        rd_valid, rd_last, frame_done, overrun;
   logic [21:0] rd_data;
   logic [1:0]  rd_ch;
   logic [3:0]  rd_bin;

   logic        s_valid, s_last, s_frame_done, s_overrun;
   logic [3:0]  s_data;
   logic [1:0]  s_ch;
   logic [3:0]  s_bin;

   int total = 0;
   int bad   = 0;
   int exp_cnt [3][16];

   always #5 clk = ~clk;

   video_hist_bank dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dv_i(dv_i), .vs_i(vs_i), .pix_i(pix_i),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ch(rd_ch), .rd_bin(rd_bin), .rd_last(rd_last),
      .rd_ready(rd_ready), .frame_done(frame_done), .overrun(overrun)
   );

   video_hist_bank #(.CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dv_i(dv_i), .vs_i(vs_i), .pix_i(pix_i),
      .rd_valid(s_valid), .rd_data(s_data), .rd_ch(s_ch), .rd_bin(s_bin), .rd_last(s_last),
      .rd_ready(rd_ready), .frame_done(s_frame_done), .overrun(s_overrun)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_exp();
      for (int c = 0; c < 3; c++)
         for (int k = 0; k < 16; k++)
            exp_cnt[c][k] = 0;
   endtask

   task automatic pixels(input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      for (int i = 0; i < n; i++) begin
         dv_i  = 1'b1;
         pix_i = {r, g, b};
         step();
      end
      dv_i = 1'b0;
   endtask

   // Sync pulse; swap lands on the third rising edge after vs_i goes active.
   task automatic swap_frame(input string tag);
      vs_i = 1'b1;
      step();
      vs_i = 1'b0;
      step();
      check({tag, " no early frame_done"}, frame_done, 0);
      step();
      check({tag, " frame_done"}, frame_done, 1);
      check({tag, " rd_valid start"}, rd_valid, 1);
   endtask

   task automatic read_frame(input int nwords, input bit toggle, input string tag);
      int got = 0;
      int cyc = 0;
      bit stalled = 0;
      int ec, eb, ev;
      logic [28:0] held = '0;
      while (got < nwords && cyc < 400) begin
         rd_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (cyc == 1) check({tag, " frame_done pulse"}, frame_done, 0);
         if (stalled) check({tag, " held"}, {rd_data, rd_ch, rd_bin, rd_last}, held);
         stalled = 0;
         if (!rd_valid) begin
            check({tag, " rd_valid"}, rd_valid, 1);
         end else if (rd_ready) begin
            ec = got / 16;
            eb = got % 16;
            ev = exp_cnt[ec][eb];
            check({tag, " rd_ch"}, rd_ch, ec);
            check({tag, " rd_bin"}, rd_bin, eb);
            check({tag, " rd_data"}, rd_data, ev);
            check({tag, " rd_last"}, rd_last, (got == nwords - 1));
            check({tag, " sat rd_data"}, s_data, (ev > 15) ? 15 : ev);
            got++;
         end else begin
            stalled = 1;
            held = {rd_data, rd_ch, rd_bin, rd_last};
         end
         step();
         cyc++;
      end
      rd_ready = 1'b1;
      check({tag, " words"}, got, nwords);
      check({tag, " idle after last"}, rd_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      step();
      step();
      check("reset rd_valid", rd_valid, 0);
      check("reset frame_done", frame_done, 0);
      check("reset overrun", overrun, 0);
      check("reset rd_last", rd_last, 0);
      check("reset rd_data", rd_data, 0);
      rst_n = 1'b1;
      step();

      // First swap after reset: old bank is empty
      clear_exp();
      swap_frame("first");
      read_frame(48, 0, "first");

      // Test 1: per-channel, 100 pixels {00,80,FF}
      pixels(100, 8'h00, 8'h80, 8'hFF);
      mode = 1'b1;
      clear_exp();
      exp_cnt[0][0] = 100; exp_cnt[1][8] = 100; exp_cnt[2][15] = 100;
      swap_frame("t1");
      read_frame(48, 0, "t1");
      check("t1 overrun", overrun, 0);

      // Test 2: luma, 64 pixels {40,40,40} -> Y = 0x40, bin 4
      pixels(64, 8'h40, 8'h40, 8'h40);
      mode = 1'b0;
      clear_exp();
      exp_cnt[0][4] = 64;
      swap_frame("t2");
      read_frame(16, 0, "t2");

      // Test 3: mixed pixels, stalled readout
      pixels(10, 8'h10, 8'h20, 8'h30);
      pixels(5, 8'hF0, 8'h00, 8'h7F);
      clear_exp();
      exp_cnt[0][1] = 10; exp_cnt[0][15] = 5;
      exp_cnt[1][2] = 10; exp_cnt[1][0]  = 5;
      exp_cnt[2][3] = 10; exp_cnt[2][7]  = 5;
      swap_frame("t3");
      read_frame(48, 1, "t3");

      // Test 4: swap while the previous readout is stalled
      pixels(7, 8'h00, 8'h00, 8'h00);
      rd_ready = 1'b0;
      swap_frame("t4a");
      pixels(3, 8'hFF, 8'hFF, 8'hFF);
      check("t4 stalled rd_bin", rd_bin, 0);
      check("t4 stalled rd_data", rd_data, 7);
      check("t4 overrun before", overrun, 0);
      clear_exp();
      exp_cnt[0][15] = 3; exp_cnt[1][15] = 3; exp_cnt[2][15] = 3;
      swap_frame("t4b");
      check("t4 overrun set", overrun, 1);
      read_frame(48, 0, "t4");

      // Test 5: 20 hits in one bin; the CNT_W=4 copy saturates at 15
      pixels(20, 8'h50, 8'h50, 8'h50);
      clear_exp();
      exp_cnt[0][5] = 20; exp_cnt[1][5] = 20; exp_cnt[2][5] = 20;
      swap_frame("t5");
      read_frame(48, 0, "t5");
      check("t5 overrun sticky", overrun, 1);

      // Test 6: pixel whose increment coincides with the swap goes to the new bank
      pixels(2, 8'h20, 8'h20, 8'h20);
      vs_i = 1'b1;
      step();
      vs_i  = 1'b0;
      dv_i  = 1'b1;
      pix_i = {8'hC0, 8'hC0, 8'hC0};
      step();
      dv_i = 1'b0;
      step();
      check("t6 frame_done", frame_done, 1);
      clear_exp();
      exp_cnt[0][2] = 2; exp_cnt[1][2] = 2; exp_cnt[2][2] = 2;
      read_frame(48, 0, "t6 old");
      clear_exp();
      exp_cnt[0][12] = 1; exp_cnt[1][12] = 1; exp_cnt[2][12] = 1;
      swap_frame("t6 new");
      read_frame(48, 0, "t6 new");

      // Reset in the middle of a readout, with counts pending in the active bank
      pixels(4, 8'h30, 8'h30, 8'h30);
      swap_frame("rst");
      step();
      step();
      pixels(5, 8'h30, 8'h30, 8'h30);
      check("rst pre rd_valid", rd_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst async rd_valid", rd_valid, 0);
      check("rst async overrun", overrun, 0);
      check("rst async rd_data", rd_data, 0);
      step();
      rst_n = 1'b1;
      step();
      clear_exp();
      swap_frame("post rst");
      read_frame(48, 0, "post rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
